// File: rtl/hazard_byp_ctrl.sv
// hazard_byp_ctrl: ID-stage load-use hazard detection and EX bypass-select
// generation. Tracks dst/we/ld of the instructions sitting in ID_EX and EX_DM,
// raises stall/bubble controls combinationally and registers the bypass selects
// so they line up with the ID_EX operand data in EX.
// Optional build macro: HZD_PERF_CNT_EN adds the saturating stall_cnt port.
module hazard_byp_ctrl #(
  parameter int REG_AW  = 4,
  parameter int R0_ZERO = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] p0_addr,
  input  logic [REG_AW-1:0] p1_addr,
  input  logic              re0,
  input  logic              re1,
  input  logic [REG_AW-1:0] dst_addr_ID,
  input  logic              we_ID,
  input  logic              ld_ID,
  input  logic              flush,
  input  logic              stall_ext,
  output logic              stall_IF_ID,
  output logic              stall_ID_EX,
  output logic              stall_EX_DM,
  output logic              bubble_ID_EX,
  output logic              byp0_EX,
  output logic              byp0_DM,
  output logic              byp1_EX,
  output logic              byp1_DM
`ifdef HZD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  // Parameter sanity; fails elaboration on nonsensical widths.
  if (REG_AW < 1) begin : g_bad_reg_aw
    $error("REG_AW must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be >= 1");
  end

  // Only ID_EX and EX_DM producers are ever consulted: a DM_WB producer is
  // covered by the write-through RF, and only the ID_EX load flag matters.
  logic [REG_AW-1:0] dst_ex_q, dst_ex_d, dst_dm_q, dst_dm_d;
  logic              we_ex_q, we_ex_d, we_dm_q, we_dm_d;
  logic              ld_ex_q, ld_ex_d;
  logic              byp0_ex_q, byp0_ex_d, byp0_dm_q, byp0_dm_d;
  logic              byp1_ex_q, byp1_ex_d, byp1_dm_q, byp1_dm_d;

  logic m0_ex, m1_ex, m0_dm, m1_dm, lu, kill_ex;

  function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] dst,
                                     input logic              we);
    return (a == dst) && we && !((R0_ZERO != 0) && (a == '0));
  endfunction

  // Hazard detect and stall/bubble outputs; everything quiet during reset.
  always_comb begin
    m0_ex        = reg_match(p0_addr, dst_ex_q, we_ex_q);
    m1_ex        = reg_match(p1_addr, dst_ex_q, we_ex_q);
    m0_dm        = reg_match(p0_addr, dst_dm_q, we_dm_q);
    m1_dm        = reg_match(p1_addr, dst_dm_q, we_dm_q);
    lu           = rst_n && ld_ex_q && ((re0 && m0_ex) || (re1 && m1_ex));
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_DM  = 1'b0;
    bubble_ID_EX = 1'b0;
    if (rst_n) begin
      if (stall_ext) begin
        stall_IF_ID = 1'b1;
        stall_ID_EX = 1'b1;
        stall_EX_DM = 1'b1;
      end else if (lu && !flush) begin
        stall_IF_ID  = 1'b1;
        bubble_ID_EX = 1'b1;
      end
    end
    // A bubble or a flush both turn the instruction entering ID_EX into a NOP.
    kill_ex = bubble_ID_EX || flush;
  end

  // Next state of the tracking pipe and bypass selects; frozen on stall_ext.
  always_comb begin
    dst_ex_d  = dst_ex_q;
    we_ex_d   = we_ex_q;
    ld_ex_d   = ld_ex_q;
    dst_dm_d  = dst_dm_q;
    we_dm_d   = we_dm_q;
    byp0_ex_d = byp0_ex_q;
    byp0_dm_d = byp0_dm_q;
    byp1_ex_d = byp1_ex_q;
    byp1_dm_d = byp1_dm_q;
    if (!stall_ext) begin
      dst_dm_d  = dst_ex_q;
      we_dm_d   = we_ex_q;
      dst_ex_d  = dst_addr_ID;
      we_ex_d   = we_ID && !kill_ex;
      ld_ex_d   = ld_ID && !kill_ex;
      // A load in ID_EX cannot forward from EX; that case is the load-use stall.
      byp0_ex_d = !kill_ex && re0 && m0_ex && !ld_ex_q;
      byp0_dm_d = !kill_ex && re0 && m0_dm;
      byp1_ex_d = !kill_ex && re1 && m1_ex && !ld_ex_q;
      byp1_dm_d = !kill_ex && re1 && m1_dm;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dst_ex_q  <= '0;
      we_ex_q   <= 1'b0;
      ld_ex_q   <= 1'b0;
      dst_dm_q  <= '0;
      we_dm_q   <= 1'b0;
      byp0_ex_q <= 1'b0;
      byp0_dm_q <= 1'b0;
      byp1_ex_q <= 1'b0;
      byp1_dm_q <= 1'b0;
    end else begin
      dst_ex_q  <= dst_ex_d;
      we_ex_q   <= we_ex_d;
      ld_ex_q   <= ld_ex_d;
      dst_dm_q  <= dst_dm_d;
      we_dm_q   <= we_dm_d;
      byp0_ex_q <= byp0_ex_d;
      byp0_dm_q <= byp0_dm_d;
      byp1_ex_q <= byp1_ex_d;
      byp1_dm_q <= byp1_dm_d;
    end
  end

  assign byp0_EX = byp0_ex_q;
  assign byp0_DM = byp0_dm_q;
  assign byp1_EX = byp1_ex_q;
  assign byp1_DM = byp1_dm_q;

`ifdef HZD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count cycles actually lost to load-use bubbles, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (lu && !flush && !stall_ext && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_byp_ctrl.sv
// Bench for hazard_byp_ctrl: table of per-cycle vectors with hand-derived
// expected comb outputs (checked mid-cycle) and registered bypass selects
// (queued at drive time, popped after the clock edge), plus a hand sequence.
module tb_hazard_byp_ctrl;
  localparam int REG_AW = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] p0_addr, p1_addr, dst_addr_ID;
  logic              re0, re1, we_ID, ld_ID, flush, stall_ext;
  logic              stall_IF_ID, stall_ID_EX, stall_EX_DM, bubble_ID_EX;
  logic              byp0_EX, byp0_DM, byp1_EX, byp1_DM;
`ifdef HZD_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  hazard_byp_ctrl #(.REG_AW(REG_AW), .R0_ZERO(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .p0_addr(p0_addr), .p1_addr(p1_addr),
    .re0(re0), .re1(re1), .dst_addr_ID(dst_addr_ID), .we_ID(we_ID),
    .ld_ID(ld_ID), .flush(flush), .stall_ext(stall_ext),
    .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_DM(stall_EX_DM), .bubble_ID_EX(bubble_ID_EX),
    .byp0_EX(byp0_EX), .byp0_DM(byp0_DM), .byp1_EX(byp1_EX), .byp1_DM(byp1_DM)
`ifdef HZD_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // cmb = {stall_IF_ID, stall_ID_EX, stall_EX_DM, bubble_ID_EX}
  // byp = {byp0_EX, byp0_DM, byp1_EX, byp1_DM} after the edge
  typedef struct {
    logic rst; logic [3:0] p0; logic [3:0] p1; logic re0; logic re1;
    logic [3:0] dst; logic we; logic ld; logic fl; logic sx;
    logic [3:0] cmb; logic [3:0] byp; int cnt;
  } vec_t;

  typedef struct { logic [3:0] byp; int cnt; } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rst, logic [3:0] p0, logic [3:0] p1,
                              logic r0, logic r1, logic [3:0] dst, logic we,
                              logic ld, logic fl, logic sx, logic [3:0] cmb,
                              logic [3:0] byp, int cnt);
    vec_t v;
    v.rst = rst; v.p0 = p0; v.p1 = p1; v.re0 = r0; v.re1 = r1;
    v.dst = dst; v.we = we; v.ld = ld; v.fl = fl; v.sx = sx;
    v.cmb = cmb; v.byp = byp; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle (called just after a posedge), check comb outputs at the
  // negedge, queue the post-edge expectation, then pop and check after the edge.
  task automatic step(input int idx, input vec_t v);
    exp_t e;
    rst_n = v.rst; p0_addr = v.p0; p1_addr = v.p1; re0 = v.re0; re1 = v.re1;
    dst_addr_ID = v.dst; we_ID = v.we; ld_ID = v.ld; flush = v.fl; stall_ext = v.sx;
    @(negedge clk);
    chk("stall_IF_ID",  idx, int'(stall_IF_ID),  int'(v.cmb[3]));
    chk("stall_ID_EX",  idx, int'(stall_ID_EX),  int'(v.cmb[2]));
    chk("stall_EX_DM",  idx, int'(stall_EX_DM),  int'(v.cmb[1]));
    chk("bubble_ID_EX", idx, int'(bubble_ID_EX), int'(v.cmb[0]));
    e.byp = v.byp; e.cnt = v.cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", idx, 0, 1);
    end else begin
      e = sb.pop_front();
      chk("byp0_EX", idx, int'(byp0_EX), int'(e.byp[3]));
      chk("byp0_DM", idx, int'(byp0_DM), int'(e.byp[2]));
      chk("byp1_EX", idx, int'(byp1_EX), int'(e.byp[1]));
      chk("byp1_DM", idx, int'(byp1_DM), int'(e.byp[0]));
`ifdef HZD_PERF_CNT_EN
      chk("stall_cnt", idx, int'(stall_cnt), e.cnt);
`endif
    end
  endtask

  initial begin
    //                rst p0 p1 r0 r1 dst we ld fl sx  cmb      byp      cnt
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0)); // 0 reset
    vecs.push_back(mk(0, 3, 0, 1, 0, 3, 1, 1, 0, 1, 4'b0000, 4'b0000, 0)); // 1 reset masks sx
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 4'b0000, 4'b0000, 0)); // 2 ADD r3
    vecs.push_back(mk(1, 3, 0, 1, 0, 7, 1, 0, 0, 0, 4'b0000, 4'b1000, 0)); // 3 read r3 -> EX
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 4'b0000, 4'b0000, 0)); // 4 ADD r5
    vecs.push_back(mk(1, 9, 0, 1, 0, 6, 1, 0, 0, 0, 4'b0000, 4'b0000, 0)); // 5 unrelated
    vecs.push_back(mk(1, 0, 5, 0, 1, 8, 1, 0, 0, 0, 4'b0000, 4'b0001, 0)); // 6 r5 on p1 -> DM
    vecs.push_back(mk(1, 5, 8, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 0)); // 7 WB no byp, p1 EX
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 4'b0000, 4'b0000, 0)); // 8 LW r2
    vecs.push_back(mk(1, 2, 2, 1, 1, 4, 1, 0, 0, 0, 4'b1001, 4'b0000, 1)); // 9 load-use
    vecs.push_back(mk(1, 2, 2, 1, 1, 4, 1, 0, 0, 0, 4'b0000, 4'b0101, 1)); // 10 both DM
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 1)); // 11 LW r0
    vecs.push_back(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 4'b0000, 4'b0000, 1)); // 12 r0 reader
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 4'b0000, 4'b0000, 1)); // 13 LW r2
    vecs.push_back(mk(1, 2, 0, 1, 0, 4, 1, 0, 1, 0, 4'b0000, 4'b0000, 1)); // 14 flush wins
    vecs.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1)); // 15 slot was killed
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 4'b0000, 4'b0000, 1)); // 16 LW r2
    vecs.push_back(mk(1, 0, 2, 0, 1, 4, 1, 0, 0, 1, 4'b1110, 4'b0000, 1)); // 17 ext stall
    vecs.push_back(mk(1, 0, 2, 0, 1, 4, 1, 0, 0, 1, 4'b1110, 4'b0000, 1)); // 18
    vecs.push_back(mk(1, 0, 2, 0, 1, 4, 1, 0, 0, 1, 4'b1110, 4'b0000, 1)); // 19
    vecs.push_back(mk(1, 0, 2, 0, 1, 4, 1, 0, 0, 0, 4'b1001, 4'b0000, 2)); // 20 hazard resumes
    vecs.push_back(mk(1, 0, 2, 0, 1, 4, 1, 0, 0, 0, 4'b0000, 4'b0001, 2)); // 21
    vecs.push_back(mk(1, 4, 0, 1, 0, 5, 1, 0, 0, 0, 4'b0000, 4'b1000, 2)); // 22 byp0_EX set
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1110, 4'b1000, 2)); // 23 byp held
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 2)); // 24
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 4'b0000, 4'b0000, 2)); // 25 LW r2
    vecs.push_back(mk(1, 2, 0, 1, 0, 4, 1, 0, 0, 1, 4'b1110, 4'b0000, 2)); // 26 mid-stall
    vecs.push_back(mk(0, 2, 0, 1, 0, 4, 1, 0, 0, 1, 4'b0000, 4'b0000, 0)); // 27 reset
    vecs.push_back(mk(1, 2, 0, 1, 0, 4, 1, 0, 0, 0, 4'b0000, 4'b0000, 0)); // 28 we cleared

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

    // Hand sequence: two writers of r6 back to back, then a reader of r6 gets
    // both EX and DM selects (downstream gives EX priority).
    step(100, mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 4'b0000, 4'b0000, 0));
    step(101, mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 4'b0000, 4'b0000, 0));
    step(102, mk(1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1100, 0));

    // Hand sequence: load-use cut short by flush on the hazard cycle, then the
    // held reader sees no hazard and no bypass from the killed slot.
    step(103, mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 4'b0000, 4'b0000, 0));
    step(104, mk(1, 0, 7, 0, 1, 7, 1, 1, 1, 0, 4'b0000, 4'b0000, 0));
    step(105, mk(1, 0, 7, 0, 1, 1, 1, 0, 0, 0, 4'b0000, 4'b0001, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
